// File: rtl/ysyx_23060184_lsu_pkg.sv
// Shared definitions for the LSU memory-access stage: widths, MemOp codes, FSM states, AXI responses.
// Optional misalign trap build: YSYX_23060184_LSU_MISALIGN_TRAP_EN.
package ysyx_23060184_lsu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned MEMOP_WIDTH = 3;
  localparam int unsigned RESP_WIDTH = 2;

  localparam logic [MEMOP_WIDTH-1:0] MEMOP_B  = 3'b000;
  localparam logic [MEMOP_WIDTH-1:0] MEMOP_H  = 3'b001;
  localparam logic [MEMOP_WIDTH-1:0] MEMOP_W  = 3'b010;
  localparam logic [MEMOP_WIDTH-1:0] MEMOP_BU = 3'b100;
  localparam logic [MEMOP_WIDTH-1:0] MEMOP_HU = 3'b101;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_DONE
  } lsu_state_e;

  // True when the access is not naturally aligned for its size.
  function automatic logic is_misaligned(input logic [MEMOP_WIDTH-1:0] op, input logic [1:0] addr_lo);
    case (op)
      MEMOP_H, MEMOP_HU: is_misaligned = addr_lo[0];
      MEMOP_W:           is_misaligned = (addr_lo != 2'b00);
      default:           is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060184_lsu_align.sv
// Byte-lane helper: store strobe/data replication and load byte/halfword extraction with extension.
module ysyx_23060184_LSU_Align
  import ysyx_23060184_lsu_pkg::*;
(
  input  logic [MEMOP_WIDTH-1:0] i_op,
  input  logic [1:0]             i_addr_lo,
  input  logic [DATA_WIDTH-1:0]  i_store_data,
  input  logic [DATA_WIDTH-1:0]  i_rdata,
  output logic [STRB_WIDTH-1:0]  o_wstrb,
  output logic [DATA_WIDTH-1:0]  o_wdata,
  output logic [DATA_WIDTH-1:0]  o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: size comes from op[1:0]; unsigned variants never reach a store.
  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_store_data;
    case (i_op[1:0])
      2'b00: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        o_wstrb = 4'b1111;
        o_wdata = i_store_data;
      end
    endcase
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_load_data = i_rdata;
    case (i_op)
      MEMOP_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
      MEMOP_BU: o_load_data = {24'h0, w_byte};
      MEMOP_H:  o_load_data = {{16{w_half[15]}}, w_half};
      MEMOP_HU: o_load_data = {16'h0, w_half};
      default:  o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060184_lsu.sv
// LSU memory-access stage: one AXI4-Lite load/store per instruction, pass-through for ALU results.
// Define YSYX_23060184_LSU_MISALIGN_TRAP_EN to fault misaligned h/hu/w accesses without a bus transaction.
module ysyx_23060184_lsu
  import ysyx_23060184_lsu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Evalid,
  output logic                   Mready,
  input  logic [DATA_WIDTH-1:0]  ALUResultE,
  input  logic [DATA_WIDTH-1:0]  WriteDataE,
  input  logic                   MemReadE,
  input  logic                   MemWriteE,
  input  logic [MEMOP_WIDTH-1:0] MemOpE,
  output logic                   Mvalid,
  input  logic                   Wready,
  output logic [DATA_WIDTH-1:0]  ALUResultM,
  output logic [DATA_WIDTH-1:0]  ReadDataM,
  output logic                   Mfault,
  output logic [ADDR_WIDTH-1:0]  araddr,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [DATA_WIDTH-1:0]  rdata,
  input  logic [RESP_WIDTH-1:0]  rresp,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [ADDR_WIDTH-1:0]  awaddr,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic [STRB_WIDTH-1:0]  wstrb,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [RESP_WIDTH-1:0]  bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  lsu_state_e             r_state;
  logic [DATA_WIDTH-1:0]  r_alu_result;
  logic [DATA_WIDTH-1:0]  r_store_data;
  logic [MEMOP_WIDTH-1:0] r_op;
  logic [DATA_WIDTH-1:0]  r_read_data;
  logic                   r_mvalid;
  logic                   r_mfault;
  logic                   r_arvalid;
  logic                   r_rready;
  logic                   r_awvalid;
  logic                   r_wvalid;
  logic                   r_bready;

  logic                   w_accept;
  logic                   w_misalign;
  logic                   w_aw_done;
  logic                   w_w_done;
  logic [STRB_WIDTH-1:0]  w_wstrb;
  logic [DATA_WIDTH-1:0]  w_wdata;
  logic [DATA_WIDTH-1:0]  w_load_data;

  // Ready depends on Wready in DONE so a new instruction can enter as the old one leaves.
  assign Mready   = (r_state == S_IDLE) || ((r_state == S_DONE) && Wready);
  assign w_accept = Evalid && Mready;

`ifdef YSYX_23060184_LSU_MISALIGN_TRAP_EN
  assign w_misalign = (MemReadE || MemWriteE) && is_misaligned(MemOpE, ALUResultE[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_aw_done = !r_awvalid || awready;
  assign w_w_done  = !r_wvalid || wready;

  ysyx_23060184_LSU_Align u_align (
    .i_op         (r_op),
    .i_addr_lo    (r_alu_result[1:0]),
    .i_store_data (r_store_data),
    .i_rdata      (rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  // Bus address/data come straight from latched registers, so they hold with their valids.
  assign araddr     = {r_alu_result[ADDR_WIDTH-1:2], 2'b00};
  assign awaddr     = {r_alu_result[ADDR_WIDTH-1:2], 2'b00};
  assign wdata      = w_wdata;
  assign wstrb      = w_wstrb;
  assign arvalid    = r_arvalid;
  assign rready     = r_rready;
  assign awvalid    = r_awvalid;
  assign wvalid     = r_wvalid;
  assign bready     = r_bready;
  assign Mvalid     = r_mvalid;
  assign Mfault     = r_mfault;
  assign ALUResultM = r_alu_result;
  assign ReadDataM  = r_read_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_alu_result <= '0;
      r_store_data <= '0;
      r_op         <= '0;
      r_read_data  <= '0;
      r_mvalid     <= 1'b0;
      r_mfault     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if ((r_state == S_DONE) && Wready) begin
            r_state  <= S_IDLE;
            r_mvalid <= 1'b0;
            r_mfault <= 1'b0;
          end
          if (w_accept) begin
            r_alu_result <= ALUResultE;
            r_store_data <= WriteDataE;
            r_op         <= MemOpE;
            r_mfault     <= 1'b0;
            if (w_misalign) begin
              r_state  <= S_DONE;
              r_mvalid <= 1'b1;
              r_mfault <= 1'b1;
            end else if (MemReadE) begin
              r_state   <= S_RD_ADDR;
              r_mvalid  <= 1'b0;
              r_arvalid <= 1'b1;
            end else if (MemWriteE) begin
              r_state   <= S_WR_REQ;
              r_mvalid  <= 1'b0;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state  <= S_DONE;
              r_mvalid <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            r_rready    <= 1'b0;
            r_read_data <= w_load_data;
            r_mfault    <= (rresp != RESP_OKAY);
            r_mvalid    <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_WR_REQ: begin
          // The two write channels retire independently; move on once both have.
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            r_bready <= 1'b0;
            r_mfault <= (bresp != RESP_OKAY);
            r_mvalid <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_23060184_lsu.md
Name: ysyx_23060184_lsu

Overview:
- Memory-access stage directly downstream of the execute stage.
- Accepts one executed instruction per handshake: address/result, store data and memory controls.
- For loads/stores, performs one AXI4-Lite-style transaction to the data memory bus, aligns and extends load data, then presents the result to writeback.
- Non-memory instructions pass through with a single cycle of occupancy.

Parameters:
- DATA_WIDTH, 32, datapath and bus data width (fixed at 32; byte-lane logic assumes 4 lanes).
- ADDR_WIDTH, 32, bus address width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- Evalid  in  1  execute stage presents a valid instruction.
- Mready  out  1  this stage can accept an instruction (feeds execute stage's Mready).
- ALUResultE  in  32  effective address (memory ops) or ALU result (others).
- WriteDataE  in  32  forwarded store data.
- MemReadE  in  1  load.
- MemWriteE  in  1  store; MemReadE and MemWriteE never both set.
- MemOpE  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- Mvalid  out  1  result valid toward writeback.
- Wready  in  1  writeback accepts.
- ALUResultM  out  32  latched ALUResultE.
- ReadDataM  out  32  aligned, extended load data.
- Mfault  out  1  bus error (or misalign, see optional feature) on this instruction.
- araddr/arvalid/arready, rdata/rresp/rvalid/rready  read channels (32/1/1, 32/2/1/1).
- awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  write channels (32/1/1, 32/4/1/1, 2/1/1).

Behaviour:
- Reset, asynchronous: state IDLE.
  - Outputs: Mvalid=0, Mready=1, Mfault=0, ALUResultM=0, ReadDataM=0.
  - All bus valids/readies = 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Accept:
  - Acceptance occurs when Evalid && Mready.
  - All E-side inputs latch on acceptance.
  - Mready=1 only in IDLE, or in DONE when Wready=1 (back-to-back).
- Transitions from IDLE (or DONE+Wready) on accept:
  - Load -> RD_ADDR.
  - Store -> WR_REQ.
  - Otherwise -> DONE. Pass-through latency is 1 cycle, accept to Mvalid.
- RD_ADDR:
  - arvalid=1, araddr = latched address with low 2 bits cleared.
  - On arready -> RD_DATA.
- RD_DATA:
  - rready=1; on rvalid, capture and extract per MemOp, then -> DONE.
  - Byte select = addr[1:0]; halfword select = addr[1].
  - b/h are sign-extended; bu/hu/w are zero-extended (w: no extension).
  - rresp != 0 sets Mfault.
- WR_REQ:
  - awvalid and wvalid both assert.
  - Each deasserts independently after its own ready. Either order, or same cycle, is legal.
  - When both have completed -> WR_RESP.
  - wdata = store data replicated into lanes (b: x4, h: x2).
  - wstrb: b = 0001<<addr[1:0]; h = 0011<<{addr[1],0}; w = 1111.
- WR_RESP:
  - bready=1; on bvalid -> DONE; bresp != 0 sets Mfault.
- DONE:
  - Mvalid=1; outputs held stable until Wready.
  - On Wready with no new accept -> IDLE, Mvalid=0, Mfault cleared.
- Valid/ready hold rules:
  - A bus valid, once raised, holds with its address/data until its ready; never withdrawn.
  - Mvalid held until Wready.
- ReadDataM is only updated by loads; otherwise it retains its previous value.
- Reset mid-transaction: the FSM aborts to IDLE and all bus valids drop immediately. Memory-side cleanup is not this block's concern.
- Outstanding transactions: max 1. No caching, no speculation.

Optional Feature:
- Macro: YSYX_23060184_LSU_MISALIGN_TRAP_EN.
- When defined:
  - h/hu with addr[0]=1, or w with addr[1:0]!=0, issues no bus transaction.
  - The instruction goes directly to DONE with Mfault=1; ReadDataM is unchanged.
- When undefined: low address bits beyond natural alignment are ignored (h forced to halfword boundary, w to word boundary) and the access proceeds normally.

Decomposition:
- Shared package/header:
  - MemOp encodings (MEMOP_B/H/W/BU/HU).
  - LSU state encoding.
  - AXI resp codes (RESP_OKAY=2'b00).
  - DATA_WIDTH/ADDR_WIDTH defines.
- One natural sub-module: ysyx_23060184_LSU_Align, purely combinational.
  - Generates wstrb/wdata from op+addr+data.
  - Extracts/extends load data from rdata+op+addr.
  - The FSM stays in the top module.

Test Plan:
- ALU pass-through: accept MemRead=MemWrite=0, ALUResultE=0x1234, Wready=1 → Mvalid=1 next cycle, ALUResultM=0x1234, no bus valid ever asserts.
- lb at 0x80000003, rdata=0x80FF_0000, ar/r ready immediate → araddr=0x80000000; ReadDataM=0xFFFFFF80. The same access as lbu → 0x00000080.
- sh data 0xABCD at 0x80000002, awready 2 cycles before wready → wstrb=1100, wdata=0xABCDABCD; WR_RESP is entered only after both channels complete; Mvalid follows bvalid.
- Backpressure: Wready=0 for 5 cycles in DONE → Mvalid, ALUResultM, ReadDataM stable and Mready=0. Wready=1 with Evalid=1 → new instruction accepted that same cycle.
- bresp=2'b10 on sw → Mfault=1 with Mvalid; cleared after Wready handshake.
- lw at 0x80000002: with the macro, Mfault=1 and arvalid never asserts; without it, araddr=0x80000000 and Mfault=0.
